// File: rtl/hex_to_7segment.sv
// ----------------------------------------------------------------------------
// hex_to_7segment
//   Registered hex-digit to seven-segment decoder.
//
//   Parameters
//     ACTIVE_LOW : 0 = lit segment driven 1, 1 = lit segment driven 0
//                  (common-anode displays).
//
//   Ports
//     clk    in   1  rising-edge clock
//     rst_n  in   1  asynchronous active-low reset, forces z to all-off
//     x      in   4  hex digit 0x0-0xF
//     en     in   1  1 = load the decode of x/blank at the clock edge, 0 = hold
//     blank  in   1  1 = load all-off regardless of x
//     z      out  7  segment drive, z[6]=a ... z[0]=g
// ----------------------------------------------------------------------------
module hex_to_7segment #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] x,
    input  logic       en,
    input  logic       blank,
    output logic [6:0] z
);

    // Pattern that turns every segment off in the selected polarity.
    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [6:0] pat_hi;   // active-high decode of x
    logic [6:0] seg;      // final pattern in output polarity
    logic [6:0] z_d;
    logic [6:0] z_q;

    // Active-high decode. Any non-matching value (X/Z in simulation) lands in
    // the default and shows nothing.
    always_comb begin
        pat_hi = 7'h00;
        case (x)
            4'h0:    pat_hi = 7'h7E;
            4'h1:    pat_hi = 7'h30;
            4'h2:    pat_hi = 7'h6D;
            4'h3:    pat_hi = 7'h79;
            4'h4:    pat_hi = 7'h33;
            4'h5:    pat_hi = 7'h5B;
            4'h6:    pat_hi = 7'h5F;
            4'h7:    pat_hi = 7'h70;
            4'h8:    pat_hi = 7'h7F;
            4'h9:    pat_hi = 7'h7B;
            4'hA:    pat_hi = 7'h77;
            4'hB:    pat_hi = 7'h1F;
            4'hC:    pat_hi = 7'h4E;
            4'hD:    pat_hi = 7'h3D;
            4'hE:    pat_hi = 7'h4F;
            4'hF:    pat_hi = 7'h47;
            default: pat_hi = 7'h00;
        endcase
    end

    // blank wins over x; polarity applied after the blank override so that
    // blank always yields SEG_OFF.
    always_comb begin
        seg = blank ? 7'h00 : pat_hi;
        if (ACTIVE_LOW) begin
            seg = ~seg;
        end
        z_d = en ? seg : z_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= SEG_OFF;
        end else begin
            z_q <= z_d;
        end
    end

    assign z = z_q;

endmodule

// File: tb/tb_hex_to_7segment.sv
module tb_hex_to_7segment;

    logic       clk;
    logic       rst_n;
    logic [3:0] x;
    logic       en;
    logic       blank;
    logic [6:0] z0;   // ACTIVE_LOW=0 instance
    logic [6:0] z1;   // ACTIVE_LOW=1 instance

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [6:0] exp0;
        logic [6:0] exp1;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    event mon_ev;

    // Hand-written active-high segment table.
    logic [6:0] pat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    hex_to_7segment #(.ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst_n(rst_n), .x(x), .en(en), .blank(blank), .z(z0));

    hex_to_7segment #(.ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .x(x), .en(en), .blank(blank), .z(z1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: the registered output is presented every cycle; compare at the
    // falling edge, or immediately when an asynchronous check is posted.
    initial begin
        forever begin
            @(negedge clk or mon_ev);
            while (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                total++;
                if (z0 !== e.exp0) begin
                    bad++;
                    $display("FAIL %s (active-high): z=%h expected %h", e.name, z0, e.exp0);
                end
                total++;
                if (z1 !== e.exp1) begin
                    bad++;
                    $display("FAIL %s (active-low): z=%h expected %h", e.name, z1, e.exp1);
                end
            end
        end
    end

    function automatic exp_t mk(input logic [6:0] hi, input string name);
        exp_t e;
        e.exp0 = hi;
        e.exp1 = ~hi;
        e.name = name;
        return e;
    endfunction

    // One clock: drive inputs, expected z after the edge is hi (active-high form).
    task automatic cyc(input logic [3:0] xv, input logic env, input logic bv,
                       input logic [6:0] hi, input string name);
        x     = xv;
        en    = env;
        blank = bv;
        @(posedge clk);
        sb_q.push_back(mk(hi, name));
        @(negedge clk);
    endtask

    // Assert reset between edges and check z right away.
    task automatic async_reset(input string name);
        #2 rst_n = 1'b0;
        #1 sb_q.push_back(mk(7'h00, name));
        -> mon_ev;
        #0;
    endtask

    initial begin
        rst_n = 1'b1;
        x     = 4'h0;
        en    = 1'b0;
        blank = 1'b0;

        // Reset behaviour
        cyc(4'h8, 1'b1, 1'b0, 7'h7F, "preload_8");
        async_reset("async_reset");
        cyc(4'h3, 1'b1, 1'b0, 7'h00, "held_in_reset");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(4'h3, 1'b0, 1'b0, 7'h00, "post_reset_en0");

        // Sweep 0..B
        for (int i = 0; i < 12; i++) cyc(4'(i), 1'b1, 1'b0, pat[i], $sformatf("sweep_%0h", i));

        // Reset mid-stream at x=C
        x  = 4'hC;
        en = 1'b1;
        async_reset("midstream_reset");
        cyc(4'hC, 1'b1, 1'b0, 7'h00, "reset_overrides_load");
        #2 rst_n = 1'b1;
        cyc(4'hC, 1'b1, 1'b0, 7'h4E, "sweep_c_after_reset");
        cyc(4'hD, 1'b1, 1'b0, 7'h3D, "sweep_d");
        cyc(4'hE, 1'b1, 1'b0, 7'h4F, "sweep_e");
        cyc(4'hF, 1'b1, 1'b0, 7'h47, "sweep_f");
        cyc(4'h0, 1'b1, 1'b0, 7'h7E, "wrap_f_to_0");
        cyc(4'h2, 1'b1, 1'b0, 7'h6D, "digit_2");
        cyc(4'hA, 1'b1, 1'b0, 7'h77, "digit_a");

        // Hold
        cyc(4'h8, 1'b1, 1'b0, 7'h7F, "hold_load_8");
        for (int i = 0; i < 4; i++) cyc(4'h1, 1'b0, 1'b0, 7'h7F, "hold_en0");
        cyc(4'h1, 1'b1, 1'b0, 7'h30, "hold_release_1");

        // Blank
        cyc(4'h5, 1'b1, 1'b1, 7'h00, "blank_on");
        cyc(4'h5, 1'b1, 1'b0, 7'h5B, "blank_off");
        cyc(4'h5, 1'b0, 1'b1, 7'h5B, "blank_ignored_en0");
        cyc(4'h0, 1'b1, 1'b0, 7'h7E, "polarity_0");
        cyc(4'h1, 1'b1, 1'b0, 7'h30, "polarity_1");

        // Final reset with polarity check
        async_reset("final_reset");

        @(negedge clk);
        @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_to_7segment.md
HEX_TO_7SEGMENT -- requirements
Module: hex_to_7segment

Parameters
REQ-001 The block SHALL have parameter ACTIVE_LOW, default 0: 0 = lit segment driven 1; 1 = lit segment driven 0 (common-anode).

Interface
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 x  input  4  hex digit to display, 0x0-0xF.
REQ-006 en  input  1  load enable: 1 = capture new decode at the clock edge; 0 = hold z.
REQ-007 blank  input  1  1 = all segments off at the next load, regardless of x.
REQ-008 z  output  7  registered segment drive; z[6]=a, z[5]=b, z[4]=c, z[3]=d, z[2]=e, z[1]=f, z[0]=g.

Function
REQ-009 Decode SHALL be purely combinational from x and blank into a 7-bit pattern; z SHALL be a register loaded from that pattern.
REQ-010 Latency SHALL be exactly one clock: x/blank sampled at rising edge N with en=1 appear on z after edge N.
REQ-011 With en=0 at a rising edge, z SHALL keep its previous value.
REQ-012 Active-high patterns (ACTIVE_LOW=0), x -> z: 0->7E, 1->30, 2->6D, 3->79, 4->33, 5->5B, 6->5F, 7->70, 8->7F, 9->7B, A->77, b->1F, C->4E, d->3D, E->4F, F->47 (hex).
REQ-013 With ACTIVE_LOW=1, z SHALL be the bitwise inverse of the REQ-012 pattern.
REQ-014 blank=1 with en=1 SHALL load the all-off pattern: 0x00 for ACTIVE_LOW=0, 0x7F for ACTIVE_LOW=1. blank SHALL take priority over x.
REQ-015 All 16 codes SHALL be decoded. No input value is illegal. If x contains X/Z in simulation, the decode SHALL default to the all-off pattern.
REQ-016 Every 4-bit value of x SHALL be decoded unambiguously, including 0xF to 0x0 wrap-around sequences, with no state carried between digits.

Reset
REQ-017 When rst_n=0, z SHALL go immediately, without waiting for a clock, to the all-off pattern (0x00 / 0x7F per ACTIVE_LOW).
REQ-018 z SHALL remain all-off while rst_n=0, regardless of clk, en, x or blank.
REQ-019 On rst_n deassertion, z SHALL stay all-off until the first rising edge with en=1.
REQ-020 Reset asserted mid-operation SHALL override any pending load.

Verification
REQ-021 The bench SHALL cover the following directed scenarios (ACTIVE_LOW=0 unless stated):
- Reset: rst_n=0 asynchronously between clock edges -> z=0x00 immediately; release, en=0 for 3 clocks -> z stays 0x00.
- Sweep: en=1, blank=0, x=0..F one per clock -> z follows REQ-012 one clock later (e.g. x=2 -> 0x6D, x=A -> 0x77, x=F -> 0x47).
- Hold: load x=8 (z=0x7F), then en=0 and x=1 for 4 clocks -> z stays 0x7F; en=1 -> z=0x30 next clock.
- Blank: x=5, blank=1, en=1 -> z=0x00; blank=0 -> z=0x5B next clock.
- Polarity: ACTIVE_LOW=1 instance, x=0 -> z=0x01; x=1 -> z=0x4F; reset -> z=0x7F.
- Reset mid-stream: during the sweep assert rst_n at x=C -> z=0x00 at once; release with x=C, en=1 -> z=0x4E after the first edge.
